multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Control FSM for the multicycle ARM datapath. It sequences fetch, decode, execute, memory and writeback over several cycles through one shared memory port and one shared ALU.
- It decodes Op/Funct using the same classes as the single-cycle main decoder: DP-register, DP-immediate, LDR, STR and B.
- It stalls on a memory ready handshake and times out hung accesses.
- It sits between the instruction register/condition-check logic and the datapath mux/enable controls.

Parameters:
- WAIT_LIMIT, 8, maximum consecutive cycles to wait for mem_ready before abort; 1 to 255.
- WCNT_W, 8, width of the wait counter; must satisfy 2^WCNT_W > WAIT_LIMIT.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- Op  in  2  instruction bits [27:26], from IR
- Funct  in  6  instruction bits [25:20]; Funct[5]=I, Funct[0]=L
- cond_ex  in  1  condition passed, from condition-check logic; valid from DECODE onward
- mem_ready  in  1  memory completes the current access this cycle
- IRWrite  out  1  load instruction register
- NextPC  out  1  write PC+4 into PC
- AdrSrc  out  1  0 = PC, 1 = ALUOut as memory address
- ALUSrcA  out  1  0 = RegA, 1 = PC
- ALUSrcB  out  2  00 = RegB, 01 = ExtImm, 10 = constant 4
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUOp  out  1  1 = decode Funct for ALU, 0 = add
- RegW  out  1  register file write
- MemW  out  1  memory write strobe
- Branch  out  1  branch target write to PC
- mem_req  out  1  memory access active
- illegal  out  1  one-cycle pulse on unimplemented Op
- mem_err  out  1  one-cycle pulse on wait timeout

Behaviour:

States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH. Outputs are Moore outputs decoded from the registered state, except where gating is noted below. Any output not listed for a state is 0.

Per-state outputs:
- FETCH: mem_req=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUOp=0, ResultSrc=10. IRWrite=NextPC=mem_ready.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ALUOp=0.
- MEMRD: mem_req=1, AdrSrc=1.
- MEMWR: mem_req=1, AdrSrc=1, MemW=cond_ex.
- MEMWB: ResultSrc=01, RegW=cond_ex.
- EXECR: ALUSrcA=0, ALUSrcB=00, ALUOp=1.
- EXECI: ALUSrcA=0, ALUSrcB=01, ALUOp=1.
- ALUWB: ResultSrc=00, RegW=cond_ex.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ALUOp=0, ResultSrc=10, Branch=cond_ex.

Transitions:
- FETCH → DECODE when mem_ready=1; otherwise stay.
- DECODE routes on Op:
  - Op=00 with Funct[5]=0 → EXECR; with Funct[5]=1 → EXECI.
  - Op=01 → MEMADR.
  - Op=10 → BRANCH.
  - Op=11 → FETCH, with illegal=1 for that cycle.
- MEMADR → MEMRD if Funct[0]=1; → MEMWR if Funct[0]=0.
- MEMRD → MEMWB when mem_ready=1.
- MEMWR → FETCH when mem_ready=1.
- EXECR, EXECI → ALUWB.
- MEMWB, ALUWB, BRANCH → FETCH.

Latency with zero wait states:
- DP: 4 cycles
- LDR: 5 cycles
- STR: 4 cycles
- B: 3 cycles
- Illegal: 2 cycles
- Each wait cycle adds 1.

Wait counter:
- Cleared on every state change.
- Increments each cycle in which mem_req=1 and mem_ready=0.
- When the count reaches WAIT_LIMIT with mem_ready still 0: pulse mem_err, go to FETCH.
- No IRWrite, NextPC, RegW or MemW is issued for the aborted access.
- mem_ready=1 in the same cycle as the limit is reached: the access completes normally and no error is raised.

Condition gating:
- cond_ex=0 suppresses RegW, MemW and Branch only.
- The state sequence is unchanged.

Reset:
- reset_n=0 forces state to FETCH and clears the wait counter immediately, asynchronously.
- While reset_n=0, all strobes are 0: IRWrite, NextPC, RegW, MemW, Branch, mem_req, illegal, mem_err.
- Mux selects take their FETCH values.
- Reset mid-instruction discards it; no partial write completes after reset asserts.
- After release, the first rising edge begins a fetch.

Test Plan:
- DP-register ADD (Op=00, Funct=001000, cond_ex=1, mem_ready=1) → states FETCH, DECODE, EXECR, ALUWB; RegW=1 only in cycle 4; next FETCH in cycle 5.
- LDR (Op=01, Funct=011001) with mem_ready low for 2 cycles in MEMRD → MEMRD held 3 cycles, MEMWB then asserts RegW=1 with ResultSrc=01; total 7 cycles.
- STR (Op=01, Funct=011000, cond_ex=0) → sequence FETCH, DECODE, MEMADR, MEMWR; MemW stays 0 throughout; returns to FETCH.
- B (Op=10, cond_ex=1) → 3 cycles, Branch=1 only in BRANCH with ALUSrcB=01. Repeat with cond_ex=0 → Branch stays 0.
- Op=11 → illegal pulses one cycle in DECODE; FETCH follows; no RegW or MemW.
- WAIT_LIMIT=4, mem_ready held 0 in FETCH → mem_err pulses after 4 wait cycles, IRWrite never asserts, FETCH restarts. Separately, assert reset_n=0 mid-MEMWR → MemW drops in the same cycle and state is FETCH.

Source files
------------

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle ARM datapath.
// It sequences fetch, decode, execute, memory and writeback through a shared
// memory port and ALU. It stalls on mem_ready and aborts an access that has
// waited WAIT_LIMIT cycles.
module multicycle_controller #(
  parameter int WAIT_LIMIT = 8,
  parameter int WCNT_W     = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       cond_ex,
  input  logic       mem_ready,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       ALUOp,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       mem_req,
  output logic       illegal,
  output logic       mem_err
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
  } state_t;

  state_t            state, state_nx;
  logic [WCNT_W-1:0] wcnt;
  logic              access;
  logic              waiting;
  logic              timeout;

  // Only Funct[5] (I) and Funct[0] (L) steer the sequence.
  logic unused_funct;
  assign unused_funct = ^Funct[4:1];

  // Memory access tracking: a wait cycle is an access cycle without ready;
  // the WAIT_LIMIT-th consecutive one aborts unless ready arrives in it.
  always_comb begin
    access  = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
    waiting = access && !mem_ready;
    timeout = waiting && (wcnt == WCNT_W'(WAIT_LIMIT - 1));
  end

  // Next-state selection.
  always_comb begin
    state_nx = state;
    case (state)
      FETCH:  state_nx = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (Op)
          2'b00:   state_nx = Funct[5] ? EXECI : EXECR;
          2'b01:   state_nx = MEMADR;
          2'b10:   state_nx = BRANCH;
          default: state_nx = FETCH;
        endcase
      end
      MEMADR: state_nx = Funct[0] ? MEMRD : MEMWR;
      MEMRD: begin
        if (mem_ready)    state_nx = MEMWB;
        else if (timeout) state_nx = FETCH;
      end
      MEMWR:  if (mem_ready || timeout) state_nx = FETCH;
      EXECR:  state_nx = ALUWB;
      EXECI:  state_nx = ALUWB;
      default: state_nx = FETCH;
    endcase
  end

  // State register and wait counter; the counter restarts on any state change
  // and after an abort, since FETCH may abort back into FETCH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= FETCH;
      wcnt  <= '0;
    end else begin
      state <= state_nx;
      if ((state_nx != state) || timeout) wcnt <= '0;
      else if (waiting)                   wcnt <= wcnt + 1'b1;
    end
  end

  // Moore output decode; strobes are forced low while reset is held so no
  // partial write escapes after reset asserts.
  always_comb begin
    IRWrite   = 1'b0;
    NextPC    = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    ALUOp     = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    mem_req   = 1'b0;
    illegal   = 1'b0;
    mem_err   = 1'b0;
    case (state)
      FETCH: begin
        mem_req   = reset_n;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = reset_n & mem_ready;
        NextPC    = reset_n & mem_ready;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        illegal   = reset_n & (Op == 2'b11);
      end
      MEMADR: ALUSrcB = 2'b01;
      MEMRD: begin
        mem_req = reset_n;
        AdrSrc  = 1'b1;
      end
      MEMWR: begin
        mem_req = reset_n;
        AdrSrc  = 1'b1;
        MemW    = reset_n & cond_ex & ~timeout;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = reset_n & cond_ex;
      end
      EXECR: ALUOp = 1'b1;
      EXECI: begin
        ALUSrcB = 2'b01;
        ALUOp   = 1'b1;
      end
      ALUWB: RegW = reset_n & cond_ex;
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        Branch    = reset_n & cond_ex;
      end
      default: ;
    endcase
    mem_err = reset_n & timeout;
  end

endmodule
